stream_deser: RTL and testbench

- Receive end of the type-parameterized beat stream used between elaborated instances.
- Accepts narrow BEAT_W-bit beats with valid/ready and an in_last frame marker.
- Reassembles beats into one word of type T and presents it on a registered valid/ready output.
- Counterpart of the serializer that splits T into beats, LSB-first.

---
 rtl/stream_deser_pkg.sv | 23 ++
 rtl/stream_deser_ctr.sv | 49 ++++
 rtl/stream_deser.sv | 145 ++++++++++++++
 tb/tb_stream_deser.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_deser_pkg.sv
// -----------------------------------------------------------------------------
// stream_deser_pkg
// Definitions shared by the beat-stream deserializer and its sub-module:
//   - state_e    : receive FSM states (COLLECT, HOLD, DRAIN)
//   - num_beats(): beats needed to carry a w-bit word in bw-bit beats
//   - ERR_*      : frame error codes, common to the serializer side
// -----------------------------------------------------------------------------
package stream_deser_pkg;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,  // accepting beats of the current word
    ST_HOLD    = 2'd1,  // output register full, waiting for the consumer
    ST_DRAIN   = 2'd2   // discarding the tail of an over-long frame
  } state_e;

  localparam logic ERR_NONE = 1'b0;  // frame length matched the word size
  localparam logic ERR_LEN  = 1'b1;  // frame was shorter or longer than the word

  function automatic int num_beats(int w, int bw);
    return (w + bw - 1) / bw;
  endfunction

endpackage

// File: rtl/stream_deser_ctr.sv
// -----------------------------------------------------------------------------
// stream_deser_ctr
// Beat position counter for the deserializer.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clear_i       : return to beat 0 (wins over incr_i)
//   incr_i        : advance to the next beat
//   count_o       : index of the beat that the next accepted beat will fill
//   at_last_o     : count_o addresses the final beat of a word
// -----------------------------------------------------------------------------
module stream_deser_ctr #(
  parameter int NUM_BEATS = 4,
  parameter int CW        = $clog2(NUM_BEATS + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          incr_i,
  output logic [CW-1:0] count_o,
  output logic          at_last_o
);

  logic [CW-1:0] count_q, count_d;

  // NOTE: every always_comb output gets a default on entry so no path
  // leaves it unassigned; that is what keeps latches from being inferred.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (incr_i) begin
      count_d = count_q + CW'(1);
    end
  end

  // NOTE: clocked state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o   = count_q;
  assign at_last_o = (count_q == CW'(NUM_BEATS - 1));

endmodule

// File: rtl/stream_deser.sv
// -----------------------------------------------------------------------------
// stream_deser
// Receive end of the beat stream: collects BEAT_W-bit beats (LSB-first) into
// one word of type T and presents it on a registered valid/ready output.
// Frames whose length differs from NUM_BEATS are flagged with out_err_o; the
// tail of an over-long frame is discarded.
// Ports:
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   in_valid_i / in_ready_o  : beat handshake
//   in_data_i                : beat payload
//   in_last_i                : final beat of the frame
//   out_valid_o / out_ready_i: word handshake
//   out_data_o               : reassembled word
//   out_err_o                : frame length error, qualified by out_valid_o
// BEAT_W must be at least 1.
// -----------------------------------------------------------------------------
module stream_deser
  import stream_deser_pkg::*;
#(
  parameter type T      = logic [31:0],
  parameter int  BEAT_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [BEAT_W-1:0] in_data_i,
  input  logic              in_last_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output T                  out_data_o,
  output logic              out_err_o
);

  localparam int W         = $bits(T);
  localparam int NUM_BEATS = num_beats(W, BEAT_W);
  localparam int PW        = NUM_BEATS * BEAT_W;
  localparam int CW        = $clog2(NUM_BEATS + 1);

  state_e          state_q, state_d;
  logic            drain_q, drain_d;  // destination after HOLD: DRAIN when set
  logic [PW-1:0]   asm_q, asm_d;
  logic [PW-1:0]   asm_word;          // assembly register with this beat merged
  logic            out_valid_q, out_valid_d;
  logic            out_err_q, out_err_d;
  T                out_data_q, out_data_d;

  logic [CW-1:0]   count;
  logic            at_last;
  logic            beat_take;
  logic            word_done;
  logic            out_fire;

  stream_deser_ctr #(
    .NUM_BEATS (NUM_BEATS),
    .CW        (CW)
  ) u_ctr (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (word_done),
    .incr_i    (beat_take && !word_done),
    .count_o   (count),
    .at_last_o (at_last)
  );

  // In HOLD the input only opens during the output handshake, and only when
  // the next stop is COLLECT, so a new word can start with no bubble.
  always_comb begin
    in_ready_o = 1'b0;
    unique case (state_q)
      ST_COLLECT: in_ready_o = 1'b1;
      ST_HOLD:    in_ready_o = out_ready_i && !drain_q;
      ST_DRAIN:   in_ready_o = 1'b1;
      default:    in_ready_o = 1'b0;
    endcase
  end

  // Beats accepted in COLLECT or in the HOLD handshake cycle are payload;
  // beats accepted in DRAIN are thrown away. The counter sits at 0 in HOLD,
  // so a beat taken there lands in slot 0.
  assign beat_take = in_valid_i && in_ready_o && (state_q != ST_DRAIN);
  assign word_done = beat_take && (in_last_i || at_last);
  assign out_fire  = out_valid_q && out_ready_i;

  // Slot 0 starts from zero, which is what zero-fills a short frame.
  always_comb begin
    asm_word = (count == '0) ? '0 : asm_q;
    for (int k = 0; k < NUM_BEATS; k++) begin
      if (count == CW'(k)) begin
        asm_word[k*BEAT_W +: BEAT_W] = in_data_i;
      end
    end
    asm_d = beat_take ? asm_word : asm_q;
  end

  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;

    if (out_fire) begin
      out_valid_d = 1'b0;
    end

    if (word_done) begin
      // A word ending without in_last is a long frame: its tail gets drained.
      state_d     = ST_HOLD;
      drain_d     = !in_last_i;
      out_valid_d = 1'b1;
      out_data_d  = T'(asm_word);  // bits at or above W are dropped here
      out_err_d   = (in_last_i && at_last) ? ERR_NONE : ERR_LEN;
    end else if (state_q == ST_HOLD && out_fire) begin
      state_d = drain_q ? ST_DRAIN : ST_COLLECT;
    end else if (state_q == ST_DRAIN && in_valid_i && in_last_i) begin
      state_d = ST_COLLECT;
    end
  end

  // NOTE: the assembly and output registers are plain flops, so they are
  // reset like any other state; a reset drops any partial or pending word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_COLLECT;
      drain_q     <= 1'b0;
      asm_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      asm_q       <= asm_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_err_o   = out_err_q;

endmodule

// File: tb/tb_stream_deser.sv
// -----------------------------------------------------------------------------
// tb_stream_deser
// Self-checking bench for stream_deser: a 32-bit/8-bit-beat instance driven by
// a table of frames, hand-written multi-cycle sequences and a randomized
// phase checked against a frame-level model, plus a 12-bit instance for the
// truncated final beat.
// -----------------------------------------------------------------------------
module tb_stream_deser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, in_last, out_valid, out_ready, out_err;
  logic [7:0]  in_data;
  logic [31:0] out_data;

  stream_deser #(.T(logic [31:0]), .BEAT_W(8)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .in_last_i   (in_last),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_err_o   (out_err)
  );

  logic        v12, rdy12, l12, ov12, or12, oe12;
  logic [7:0]  d12;
  logic [11:0] od12;

  stream_deser #(.T(logic [11:0]), .BEAT_W(8)) dut12 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (v12),
    .in_ready_o  (rdy12),
    .in_data_i   (d12),
    .in_last_i   (l12),
    .out_valid_o (ov12),
    .out_ready_i (or12),
    .out_data_o  (od12),
    .out_err_o   (oe12)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } word_t;

  typedef struct {
    int          len;
    logic [47:0] beats;     // beat i = beats[8*i +: 8]
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  word_t       exp_q[$];
  logic [7:0]  frame_q[$];
  logic        model_on    = 1'b0;
  logic        model_drain = 1'b0;
  logic        stall_q     = 1'b0;
  logic [31:0] stall_data;
  logic        stall_err;
  logic        took;
  vec_t        tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  // Frame-level reference: a word is the first four beats of a frame, LSB
  // first, zero above what arrived; error unless exactly four beats with the
  // last one flagged. After four beats without in_last the rest is ignored.
  task automatic model_beat(input logic [7:0] d, input logic l);
    word_t       w;
    logic [31:0] wv;
    if (model_drain) begin
      if (l) model_drain = 1'b0;
    end else begin
      frame_q.push_back(d);
      if (l || frame_q.size() == 4) begin
        wv = '0;
        foreach (frame_q[i]) wv = wv | (32'(frame_q[i]) << (8 * i));
        w.data = wv;
        w.err  = !(l && frame_q.size() == 4);
        exp_q.push_back(w);
        model_drain = !l;
        frame_q.delete();
      end
    end
  endtask

  task automatic observe();
    word_t w;
    if (stall_q) begin
      check("stall_valid", {31'b0, out_valid}, 32'd1);
      check("stall_data", out_data, stall_data);
      check("stall_err", {31'b0, out_err}, {31'b0, stall_err});
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        fail_now("unexpected_word");
      end else begin
        w = exp_q.pop_front();
        check("word_data", out_data, w.data);
        check("word_err", {31'b0, out_err}, {31'b0, w.err});
      end
    end
    stall_q    = out_valid && !out_ready;
    stall_data = out_data;
    stall_err  = out_err;
  endtask

  // One clock: drive at the falling edge, sample 1 ns later.
  task automatic cycle(input logic v, input logic [7:0] d, input logic l,
                       input logic r, output logic tk);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = r;
    #1;
    tk = v && in_ready;
    observe();
    if (tk && model_on) model_beat(d, l);
  endtask

  task automatic send_beat(input logic [7:0] d, input logic l, input logic r);
    logic tk;
    int   n;
    n = 0;
    do begin
      cycle(1'b1, d, l, r, tk);
      n++;
    end while (!tk && n < 100);
    if (!tk) fail_now("beat_timeout");
  endtask

  task automatic send_beat_rand(input logic [7:0] d, input logic l);
    logic tk, v, r;
    int   n;
    n = 0;
    do begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 9) < 7);
      cycle(v, v ? d : 8'h00, v ? l : 1'b0, r, tk);
      n++;
    end while (!tk && n < 200);
    if (!tk) fail_now("rand_beat_timeout");
  endtask

  task automatic idle(input int n);
    logic tk;
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1, tk);
  endtask

  task automatic drain_expect(input string name);
    logic tk;
    int   n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b1, tk);
      n++;
    end
    check(name, exp_q.size(), 32'd0);
  endtask

  task automatic push_exp(input logic [31:0] d, input logic e);
    word_t w;
    w.data = d;
    w.err  = e;
    exp_q.push_back(w);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_data"}, out_data, 32'd0);
    check({tag, "_err"}, {31'b0, out_err}, 32'd0);
    check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bv;
    logic [7:0] rb;
    int         len;

    tbl[0] = '{4, 48'h0000_12345678, 32'h12345678, 1'b0};
    tbl[1] = '{2, 48'h0000_0000BBAA, 32'h0000BBAA, 1'b1};
    tbl[2] = '{4, 48'h0000_44332211, 32'h44332211, 1'b0};
    tbl[3] = '{6, 48'hA6A5_A4A3A2A1, 32'hA4A3A2A1, 1'b1};
    tbl[4] = '{4, 48'h0000_CAFEF00D, 32'hCAFEF00D, 1'b0};
    tbl[5] = '{1, 48'h0000_0000005A, 32'h0000005A, 1'b1};
    tbl[6] = '{5, 48'h00C5_C4C3C2C1, 32'hC4C3C2C1, 1'b1};
    tbl[7] = '{4, 48'h0000_87654321, 32'h87654321, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b1;
    v12 = 1'b0; d12 = 8'h00; l12 = 1'b0; or12 = 1'b1;

    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    check("reset12_valid", {31'b0, ov12}, 32'd0);
    check("reset12_data", {20'b0, od12}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Normal frame: one-cycle latency, single-cycle valid.
    push_exp(32'h12345678, 1'b0);
    send_beat(8'h78, 1'b0, 1'b1);
    send_beat(8'h56, 1'b0, 1'b1);
    send_beat(8'h34, 1'b0, 1'b1);
    cycle(1'b1, 8'h12, 1'b1, 1'b1, took);
    check("last_beat_taken", {31'b0, took}, 32'd1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, took);
    check("latency_valid", {31'b0, out_valid}, 32'd1);
    check("latency_data", out_data, 32'h12345678);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, took);
    check("single_cycle_valid", {31'b0, out_valid}, 32'd0);

    // Backpressure: output held, input closed, next beat 0 taken on handshake.
    push_exp(32'h12345678, 1'b0);
    push_exp(32'h04030201, 1'b0);
    send_beat(8'h78, 1'b0, 1'b0);
    send_beat(8'h56, 1'b0, 1'b0);
    send_beat(8'h34, 1'b0, 1'b0);
    send_beat(8'h12, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 8'h01, 1'b0, 1'b0, took);
      check("hold_in_ready", {31'b0, in_ready}, 32'd0);
      check("hold_out_data", out_data, 32'h12345678);
    end
    cycle(1'b1, 8'h01, 1'b0, 1'b1, took);
    check("handshake_beat0_taken", {31'b0, took}, 32'd1);
    send_beat(8'h02, 1'b0, 1'b1);
    send_beat(8'h03, 1'b0, 1'b1);
    send_beat(8'h04, 1'b1, 1'b1);
    drain_expect("hold_scoreboard_empty");

    // Table of frames: good, short, long and zero-fill cases back to back.
    for (int i = 0; i < 8; i++) begin
      push_exp(tbl[i].exp_data, tbl[i].exp_err);
      len = tbl[i].len;
      for (int b = 0; b < len; b++) begin
        bv = tbl[i].beats[8*b +: 8];
        send_beat(bv, (b == len - 1), 1'b1);
      end
    end
    drain_expect("table_scoreboard_empty");

    // Reset with a pending output word, then reset mid-frame.
    send_beat(8'h78, 1'b0, 1'b0);
    send_beat(8'h56, 1'b0, 1'b0);
    send_beat(8'h34, 1'b0, 1'b0);
    send_beat(8'h12, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, took);
    check("pre_reset_valid", {31'b0, out_valid}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check_reset_outputs("rst_hold");
    stall_q = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send_beat(8'h55, 1'b0, 1'b1);
    send_beat(8'h66, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    push_exp(32'h12345678, 1'b0);
    send_beat(8'h78, 1'b0, 1'b1);
    send_beat(8'h56, 1'b0, 1'b1);
    send_beat(8'h34, 1'b0, 1'b1);
    send_beat(8'h12, 1'b1, 1'b1);
    drain_expect("post_reset_scoreboard_empty");

    // 12-bit word: upper nibble of the final beat is discarded.
    @(negedge clk);
    v12 = 1'b1; d12 = 8'hCD; l12 = 1'b0;
    #1;
    check("w12_in_ready", {31'b0, rdy12}, 32'd1);
    @(negedge clk);
    d12 = 8'hFB; l12 = 1'b1;
    @(negedge clk);
    v12 = 1'b0; l12 = 1'b0;
    #1;
    check("w12_valid", {31'b0, ov12}, 32'd1);
    check("w12_data", {20'b0, od12}, 32'h00000BCD);
    check("w12_err", {31'b0, oe12}, 32'd0);
    @(negedge clk);
    v12 = 1'b1; d12 = 8'h3C; l12 = 1'b1;
    #1;
    check("w12_single_cycle", {31'b0, ov12}, 32'd0);
    @(negedge clk);
    v12 = 1'b0; l12 = 1'b0;
    #1;
    check("w12_short_valid", {31'b0, ov12}, 32'd1);
    check("w12_short_data", {20'b0, od12}, 32'h0000003C);
    check("w12_short_err", {31'b0, oe12}, 32'd1);

    // Randomized frames against the frame-level model.
    model_on    = 1'b1;
    model_drain = 1'b0;
    frame_q.delete();
    for (int f = 0; f < 150; f++) begin
      len = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : 4;
      for (int b = 0; b < len; b++) begin
        rb = 8'($urandom_range(0, 255));
        send_beat_rand(rb, (b == len - 1));
      end
    end
    drain_expect("random_scoreboard_empty");
    model_on = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
